fetch_stage: RTL and testbench

Instruction-fetch stage of the custom 4-stage 8-bit pipeline. Owns the program counter, addresses the asynchronous-read instruction memory, and loads the IF/ID pipeline register. Resolves unconditional jumps (opcode `2'b11`) from the IF/ID register with a one-bubble penalty. Honours a stall from the hazard logic and a redirect from a later stage.

---
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, loads the IF/ID register and resolves
// unconditional jumps sitting in IF/ID with a single bubble of penalty.
module fetch_stage #(
  parameter int         MEM_DEPTH = 36,
  parameter logic [7:0] RESET_PC  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       redirect_en,
  input  logic [7:0] redirect_pc,
  input  logic [7:0] Instruction_Code,
  output logic [7:0] PC,
  output logic [7:0] if_id_instr,
  output logic [7:0] if_id_pc,
  output logic       if_id_valid,
  output logic       jump_taken,
  output logic       fetch_done
);

  // The PC is 8 bits, so a depth above 256 behaves like 256.
  localparam int         DEPTH_C = (MEM_DEPTH > 256) ? 256 : ((MEM_DEPTH < 0) ? 0 : MEM_DEPTH);
  localparam logic [8:0] DEPTH_W = 9'(DEPTH_C);
  localparam logic [1:0] OP_J    = 2'b11;

  logic [7:0] pc_q;
  logic [7:0] pc_d;
  logic [7:0] instr_q;
  logic [7:0] instr_d;
  logic [7:0] ifpc_q;
  logic [7:0] ifpc_d;
  logic       valid_q;
  logic       valid_d;

  logic       jump_pending_s;
  logic       jump_fire_s;
  logic       done_s;
  logic [7:0] jump_target_s;
  logic [7:0] pc_inc_s;

  function automatic logic [7:0] sext6(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction

  // Jump decode, target arithmetic and end-of-program detection.
  always_comb begin
    jump_pending_s = valid_q && (instr_q[7:6] == OP_J);
    jump_target_s  = ifpc_q + 8'd1 + sext6(instr_q[5:0]);
    pc_inc_s       = pc_q + 8'd1;
    done_s         = ({1'b0, pc_q} >= DEPTH_W);
    jump_fire_s    = jump_pending_s && !reset && !redirect_en && !stall;
  end

  // Next-state selection below reset: redirect, stall, jump, done, normal fetch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    if (redirect_en) begin
      pc_d    = redirect_pc;
      instr_d = 8'h00;
      ifpc_d  = 8'h00;
      valid_d = 1'b0;
    end else if (stall) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      valid_d = valid_q;
    end else if (jump_pending_s) begin
      // The word at the current PC is squashed; IF/ID becomes the bubble.
      pc_d    = jump_target_s;
      instr_d = 8'h00;
      ifpc_d  = 8'h00;
      valid_d = 1'b0;
    end else if (done_s) begin
      pc_d    = pc_q;
      instr_d = 8'h00;
      ifpc_d  = 8'h00;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_inc_s;
      instr_d = Instruction_Code;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 8'h00;
      ifpc_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign PC          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign jump_taken  = jump_fire_s;
  assign fetch_done  = done_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: two instances (short program memory and
// full 256-word space starting at 8'hFF) checked against a behavioural model.
module tb_fetch_stage;

  localparam int         DEPTH0 = 6;
  localparam int         DEPTH1 = 256;
  localparam logic [7:0] RPC0   = 8'h00;
  localparam logic [7:0] RPC1   = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       stall;
  logic       redirect_en;
  logic [7:0] redirect_pc;
  logic [7:0] mem [0:255];

  logic [7:0] pc_w [2];
  logic [7:0] instr_w [2];
  logic [7:0] ifpc_w [2];
  logic       valid_w [2];
  logic       jt_w [2];
  logic       fd_w [2];
  logic [7:0] ic0;
  logic [7:0] ic1;

  assign ic0 = mem[pc_w[0]];
  assign ic1 = mem[pc_w[1]];

  fetch_stage #(.MEM_DEPTH(DEPTH0), .RESET_PC(RPC0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .Instruction_Code(ic0), .PC(pc_w[0]),
    .if_id_instr(instr_w[0]), .if_id_pc(ifpc_w[0]), .if_id_valid(valid_w[0]),
    .jump_taken(jt_w[0]), .fetch_done(fd_w[0])
  );

  fetch_stage #(.MEM_DEPTH(DEPTH1), .RESET_PC(RPC1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .Instruction_Code(ic1), .PC(pc_w[1]),
    .if_id_instr(instr_w[1]), .if_id_pc(ifpc_w[1]), .if_id_valid(valid_w[1]),
    .jump_taken(jt_w[1]), .fetch_done(fd_w[1])
  );

  typedef struct packed {
    logic       chk;
    logic [7:0] pc;
    logic [7:0] instr;
    logic [7:0] ifpc;
    logic       valid;
    logic       jt;
    logic       fd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int compared   = 0;
  int mismatched = 0;

  // Reference model state (one per instance)
  logic [7:0] m_pc [2];
  logic [7:0] m_instr [2];
  logic [7:0] m_ifpc [2];
  logic       m_valid [2];
  logic       m_known [2];

  task automatic bubble(input int i);
    m_instr[i] = 8'h00;
    m_ifpc[i]  = 8'h00;
    m_valid[i] = 1'b0;
  endtask

  // Records what instance i shows this cycle, then advances it across the coming edge.
  task automatic step(input int i);
    exp_t       e;
    int         dep;
    int         off;
    int         tgt;
    logic [7:0] rpc;
    logic       jt;
    dep = (i == 0) ? DEPTH0 : DEPTH1;
    rpc = (i == 0) ? RPC0 : RPC1;
    jt  = !reset && !redirect_en && !stall && m_valid[i] && (m_instr[i][7:6] == 2'b11);
    e.chk   = m_known[i];
    e.pc    = m_pc[i];
    e.instr = m_instr[i];
    e.ifpc  = m_ifpc[i];
    e.valid = m_valid[i];
    e.jt    = jt;
    e.fd    = (int'(m_pc[i]) >= dep);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
    if (reset) begin
      m_pc[i] = rpc;
      bubble(i);
      m_known[i] = 1'b1;
    end else if (redirect_en) begin
      m_pc[i] = redirect_pc;
      bubble(i);
    end else if (stall) begin
      m_pc[i] = m_pc[i];
    end else if (jt) begin
      off = int'(m_instr[i][5:0]);
      if (off >= 32) off = off - 64;
      tgt = (int'(m_ifpc[i]) + 1 + off + 256) % 256;
      m_pc[i] = 8'(tgt);
      bubble(i);
    end else if (e.fd) begin
      bubble(i);
    end else begin
      m_instr[i] = mem[m_pc[i]];
      m_ifpc[i]  = m_pc[i];
      m_valid[i] = 1'b1;
      m_pc[i]    = 8'((int'(m_pc[i]) + 1) % 256);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic re, input logic [7:0] rp);
    @(negedge clk);
    reset = r;
    stall = s;
    redirect_en = re;
    redirect_pc = rp;
    #1;
    step(0);
    step(1);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: pops one expected record per instance per cycle and compares.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      logic have;
      have = 1'b0;
      if (i == 0 && q0.size() > 0) begin
        e = q0.pop_front();
        have = 1'b1;
      end else if (i == 1 && q1.size() > 0) begin
        e = q1.pop_front();
        have = 1'b1;
      end
      if (have && e.chk) begin
        compared++;
        if (pc_w[i] !== e.pc || instr_w[i] !== e.instr || ifpc_w[i] !== e.ifpc ||
            valid_w[i] !== e.valid || jt_w[i] !== e.jt || fd_w[i] !== e.fd) begin
          mismatched++;
          $display("FAIL state dut%0d t=%0t: got pc=%h instr=%h ifpc=%h v=%b jt=%b fd=%b exp pc=%h instr=%h ifpc=%h v=%b jt=%b fd=%b",
                   i, $time, pc_w[i], instr_w[i], ifpc_w[i], valid_w[i], jt_w[i], fd_w[i],
                   e.pc, e.instr, e.ifpc, e.valid, e.jt, e.fd);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 8'h00;
    for (int j = 0; j < 256; j++) mem[j] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 8'h00;
      bubble(i);
      m_known[i] = 1'b0;
    end

    // Program with a forward jump at pc3 over 8'h43
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    mem[0] = 8'h23; mem[1] = 8'h61; mem[2] = 8'h02;
    mem[3] = 8'hC1; mem[4] = 8'h43; mem[5] = 8'h14;
    run(2);
    chk("dut1_first_ifpc", ifpc_w[1], 8'hFF);
    chk("dut1_first_valid", {7'd0, valid_w[1]}, 8'h01);
    chk("dut1_pc_wrap", pc_w[1], 8'h00);
    run(10);
    chk("end_pc", pc_w[0], 8'h06);
    chk("end_done", {7'd0, fd_w[0]}, 8'h01);

    // Self-loop jump
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    mem[3] = 8'hFF;
    run(12);

    // Stall held across a pending jump
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    mem[3] = 8'hC1;
    run(4);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("stall_pc", pc_w[0], 8'h04);
    chk("stall_ifpc", ifpc_w[0], 8'h03);
    chk("stall_instr", instr_w[0], 8'hC1);
    chk("stall_jt", {7'd0, jt_w[0]}, 8'h00);
    run(4);

    // Redirect beats stall and a pending jump
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    run(4);
    cyc(1'b0, 1'b1, 1'b1, 8'h01);
    run(1);
    chk("redir_pc", pc_w[0], 8'h01);
    chk("redir_valid", {7'd0, valid_w[0]}, 8'h00);
    run(3);

    // Reset mid-program
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    run(4);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    run(1);
    chk("rst_pc", pc_w[0], 8'h00);
    chk("rst_valid", {7'd0, valid_w[0]}, 8'h00);
    run(5);

    // Randomized traffic; memory is only rewritten ahead of a reset edge
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 2500; k++) begin
      logic       r;
      logic       s;
      logic       re;
      logic [7:0] rp;
      if (k == 0 || reset) begin
        for (int j = 0; j < 256; j++) begin
          mem[j] = 8'($urandom);
          if ($urandom_range(0, 9) == 0) mem[j] = 8'hFF;
        end
      end
      r  = ($urandom_range(0, 79) == 0);
      s  = ($urandom_range(0, 4) == 0);
      re = ($urandom_range(0, 9) == 0);
      rp = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      cyc(r, s, re, rp);
    end
    run(2);
    @(negedge clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
